// File: rtl/sha256_pkg.sv
// Shared constants and types for the SHA-256 message-schedule sequencer.
package sha256_pkg;

  localparam int WORD_W      = 32;
  localparam int BLOCK_WORDS = 16;
  localparam int MAX_ROUNDS  = 64;
  localparam int IDX_W       = 6;
  localparam int CNT_W       = 4;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic {
    LOAD = 1'b0,
    EMIT = 1'b1
  } sched_state_e;

endpackage

// File: rtl/sha256_msg_sched_if.sv
// Stream bundle between block padder (input side), schedule sequencer and round engine (output side).
interface sha256_msg_sched_if;
  import sha256_pkg::*;

  logic               clear;
  logic               in_valid;
  logic               in_ready;
  word_t              in_data;
  logic               out_valid;
  logic               out_ready;
  word_t              out_data;
  logic [IDX_W-1:0]   out_idx;
  logic               out_last;
  logic               busy;

  modport master (
    output clear, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last, busy
  );

  modport slave (
    input  clear, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last, busy
  );

endinterface

// File: rtl/sha256_msg_sched_word_gen.sv
// Small-sigma functions and the combinational schedule-word generator
// W[t+16] = s1(W[t+14]) + W[t+9] + s0(W[t+1]) + W[t].
module lsigma0
  import sha256_pkg::*;
(
  input  word_t x,
  output word_t y
);
  assign y = {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
endmodule

module lsigma1
  import sha256_pkg::*;
(
  input  word_t x,
  output word_t y
);
  assign y = {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
endmodule

module msg_word_gen
  import sha256_pkg::*;
(
  input  word_t w0,
  input  word_t w1,
  input  word_t w9,
  input  word_t w14,
  output word_t new_word
);
  word_t s0;
  word_t s1;

  lsigma0 u_s0 (
    .x (w1),
    .y (s0)
  );

  lsigma1 u_s1 (
    .x (w14),
    .y (s1)
  );

  // Carries out of bit 31 drop naturally in the 32-bit sum.
  assign new_word = s1 + w9 + s0 + w0;
endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule sequencer: loads 16 words into a sliding window,
// then emits W[0..NUM_ROUNDS-1] one word per output handshake.
module sha256_msg_sched
  import sha256_pkg::*;
#(
  parameter int NUM_ROUNDS = 64
) (
  input logic               clk,
  input logic               rst_n,
  sha256_msg_sched_if.slave bus
);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_ROUNDS - 1);
  localparam logic [CNT_W-1:0] LAST_LOAD = CNT_W'(BLOCK_WORDS - 1);

  sched_state_e       state_reg;
  sched_state_e       state_next;
  logic [CNT_W-1:0]   load_cnt_reg;
  logic [CNT_W-1:0]   load_cnt_next;
  logic [IDX_W-1:0]   idx_reg;
  logic [IDX_W-1:0]   idx_next;
  word_t              win_reg [BLOCK_WORDS];
  word_t              new_word;
  word_t              shift_word;
  logic               shift_en;

  msg_word_gen u_gen (
    .w0       (win_reg[0]),
    .w1       (win_reg[1]),
    .w9       (win_reg[9]),
    .w14      (win_reg[14]),
    .new_word (new_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= LOAD;
      load_cnt_reg <= '0;
      idx_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      load_cnt_reg <= load_cnt_next;
      idx_reg      <= idx_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    load_cnt_next = load_cnt_reg;
    idx_next      = idx_reg;
    shift_en      = 1'b0;
    shift_word    = new_word;

    bus.in_ready  = (state_reg == LOAD);
    bus.out_valid = (state_reg == EMIT);
    bus.busy      = (state_reg == EMIT);
    bus.out_last  = (state_reg == EMIT) && (idx_reg == LAST_IDX);
    bus.out_data  = win_reg[0];
    bus.out_idx   = idx_reg;

    // clear outranks any handshake in the same cycle, which is then discarded.
    if (bus.clear) begin
      state_next    = LOAD;
      load_cnt_next = '0;
      idx_next      = '0;
    end else begin
      case (state_reg)
        LOAD: begin
          if (bus.in_valid) begin
            shift_en   = 1'b1;
            shift_word = bus.in_data;
            if (load_cnt_reg == LAST_LOAD) begin
              load_cnt_next = '0;
              state_next    = EMIT;
            end else begin
              load_cnt_next = load_cnt_reg + 1'b1;
            end
          end
        end
        EMIT: begin
          if (bus.out_ready) begin
            shift_en = 1'b1;
            if (idx_reg == LAST_IDX) begin
              idx_next   = '0;
              state_next = LOAD;
            end else begin
              idx_next = idx_reg + 1'b1;
            end
          end
        end
        default: begin
          state_next = LOAD;
        end
      endcase
    end
  end

  // Sliding window: each stage takes its upper neighbour, the top takes the new word.
  for (genvar gi = 0; gi < BLOCK_WORDS; gi++) begin : g_win
    if (gi < BLOCK_WORDS - 1) begin : g_mid
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          win_reg[gi] <= '0;
        end else if (shift_en) begin
          win_reg[gi] <= win_reg[gi+1];
        end
      end
    end else begin : g_top
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          win_reg[gi] <= '0;
        end else if (shift_en) begin
          win_reg[gi] <= shift_word;
        end
      end
    end
  end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Bench for sha256_msg_sched: randomized blocks checked against a plain-arithmetic schedule model.
module tb_sha256_msg_sched;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sha256_msg_sched_if if64 ();
  sha256_msg_sched_if if16 ();

  // index 0: NUM_ROUNDS=64 instance, index 1: NUM_ROUNDS=16 instance
  logic        tb_clear     [2];
  logic        tb_in_valid  [2];
  logic [31:0] tb_in_data   [2];
  logic        tb_out_ready [2];
  logic        o_in_ready   [2];
  logic        o_out_valid  [2];
  logic [31:0] o_data       [2];
  logic [5:0]  o_idx        [2];
  logic        o_last       [2];
  logic        o_busy       [2];

  assign if64.clear     = tb_clear[0];
  assign if64.in_valid  = tb_in_valid[0];
  assign if64.in_data   = tb_in_data[0];
  assign if64.out_ready = tb_out_ready[0];
  assign o_in_ready[0]  = if64.in_ready;
  assign o_out_valid[0] = if64.out_valid;
  assign o_data[0]      = if64.out_data;
  assign o_idx[0]       = if64.out_idx;
  assign o_last[0]      = if64.out_last;
  assign o_busy[0]      = if64.busy;

  assign if16.clear     = tb_clear[1];
  assign if16.in_valid  = tb_in_valid[1];
  assign if16.in_data   = tb_in_data[1];
  assign if16.out_ready = tb_out_ready[1];
  assign o_in_ready[1]  = if16.in_ready;
  assign o_out_valid[1] = if16.out_valid;
  assign o_data[1]      = if16.out_data;
  assign o_idx[1]       = if16.out_idx;
  assign o_last[1]      = if16.out_last;
  assign o_busy[1]      = if16.busy;

  sha256_msg_sched #(.NUM_ROUNDS(64)) u_dut64 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if64)
  );

  sha256_msg_sched #(.NUM_ROUNDS(16)) u_dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if16)
  );

  int n_total = 0;
  int n_pass  = 0;

  logic [31:0] blk   [16];
  logic [31:0] ref_w [64];
  logic [31:0] got_w [64];
  int got_n;
  int anomalies;
  int emit_cycles;
  int load_n;
  int load_cycles;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    logic [63:0] dd;
    dd = {x, x} >> n;
    return dd[31:0];
  endfunction

  function automatic logic [31:0] ss0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ss1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic ref_sched();
    for (int t = 0; t < 16; t++) ref_w[t] = blk[t];
    for (int t = 16; t < 64; t++)
      ref_w[t] = ss1(ref_w[t-2]) + ref_w[t-7] + ss0(ref_w[t-15]) + ref_w[t-16];
  endtask

  task automatic make_block(input bit abc);
    for (int i = 0; i < 16; i++) blk[i] = abc ? 32'h0 : $urandom;
    if (abc) begin
      blk[0]  = 32'h61626380;
      blk[15] = 32'h00000018;
    end
    ref_sched();
  endtask

  task automatic load_block(input int d, input int nwords, input int gap_pct);
    logic fire;
    load_n = 0;
    load_cycles = 0;
    while (load_n < nwords && load_cycles < 1000) begin
      tb_in_valid[d] = (int'($urandom_range(99)) >= gap_pct);
      tb_in_data[d]  = tb_in_valid[d] ? blk[load_n] : $urandom;
      fire = tb_in_valid[d] & o_in_ready[d];
      @(posedge clk); #1;
      load_cycles++;
      if (fire) load_n++;
    end
    tb_in_valid[d] = 1'b0;
  endtask

  // Drains one block, recording accepted words and any protocol irregularity.
  task automatic emit_collect(input int d, input int rounds, input int stall_pct);
    int   expect_idx;
    logic stalled;
    logic rdy;
    logic [31:0] prev_data;
    expect_idx = 0; stalled = 1'b0; prev_data = '0;
    got_n = 0; anomalies = 0; emit_cycles = 0;
    for (int i = 0; i < 64; i++) got_w[i] = 32'hxxxxxxxx;
    while (got_n < rounds && emit_cycles < 4000) begin
      if (o_out_valid[d] !== 1'b1 || o_busy[d] !== 1'b1 || o_in_ready[d] !== 1'b0) anomalies++;
      if (o_idx[d] !== 6'(expect_idx)) anomalies++;
      if (o_last[d] !== (expect_idx == rounds - 1)) anomalies++;
      if (stalled && o_data[d] !== prev_data) anomalies++;
      rdy = (int'($urandom_range(99)) >= stall_pct);
      tb_out_ready[d] = rdy;
      tb_in_valid[d]  = 1'($urandom_range(1));
      tb_in_data[d]   = $urandom;
      if (rdy && o_out_valid[d]) begin
        got_w[got_n] = o_data[d];
        got_n++;
        expect_idx++;
      end
      stalled   = !rdy;
      prev_data = o_data[d];
      @(posedge clk); #1;
      emit_cycles++;
    end
    tb_out_ready[d] = 1'b0;
    tb_in_valid[d]  = 1'b0;
  endtask

  function automatic int count_bad(input int rounds);
    int bad = 0;
    for (int t = 0; t < rounds; t++) if (got_w[t] !== ref_w[t]) bad++;
    return bad;
  endfunction

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      n_total++; if (o_in_ready[d] !== 1'b1) $display("FAIL reset_in_ready[%0d]: got %b required 1", d, o_in_ready[d]); else n_pass++;
      n_total++; if (o_out_valid[d] !== 1'b0) $display("FAIL reset_out_valid[%0d]: got %b required 0", d, o_out_valid[d]); else n_pass++;
      n_total++; if (o_data[d] !== 32'h0) $display("FAIL reset_out_data[%0d]: got %h required 0", d, o_data[d]); else n_pass++;
      n_total++; if (o_idx[d] !== 6'd0 || o_last[d] !== 1'b0 || o_busy[d] !== 1'b0)
        $display("FAIL reset_idx_last_busy[%0d]: got %0d/%b/%b required 0/0/0", d, o_idx[d], o_last[d], o_busy[d]); else n_pass++;
    end
    $display("test_reset done");
  endtask

  task automatic test_abc();
    make_block(1'b1);
    load_block(0, 16, 0);
    n_total++; if (load_cycles !== 16) $display("FAIL abc_load_cycles: got %0d required 16", load_cycles); else n_pass++;
    emit_collect(0, 64, 0);
    n_total++; if (got_n !== 64) $display("FAIL abc_word_count: got %0d required 64", got_n); else n_pass++;
    n_total++; if (emit_cycles !== 64) $display("FAIL abc_emit_cycles: got %0d required 64", emit_cycles); else n_pass++;
    n_total++; if (anomalies !== 0) $display("FAIL abc_protocol: got %0d anomalies required 0", anomalies); else n_pass++;
    n_total++; if (got_w[16] !== 32'h61626380) $display("FAIL abc_w16: got %h required 61626380", got_w[16]); else n_pass++;
    n_total++; if (got_w[17] !== 32'h000F0000) $display("FAIL abc_w17: got %h required 000f0000", got_w[17]); else n_pass++;
    n_total++; if (got_w[63] !== ref_w[63]) $display("FAIL abc_w63: got %h required %h", got_w[63], ref_w[63]); else n_pass++;
    n_total++; if (count_bad(64) !== 0) $display("FAIL abc_words: got %0d bad words required 0", count_bad(64)); else n_pass++;
    n_total++; if (o_in_ready[0] !== 1'b1 || o_out_valid[0] !== 1'b0)
      $display("FAIL abc_return_load: got in_ready=%b out_valid=%b required 1/0", o_in_ready[0], o_out_valid[0]); else n_pass++;
    $display("test_abc done: w63=%h", got_w[63]);
  endtask

  task automatic test_random_stall();
    for (int b = 0; b < 3; b++) begin
      make_block(1'b0);
      load_block(0, 16, 0);
      emit_collect(0, 64, 50);
      n_total++; if (got_n !== 64) $display("FAIL stall_word_count: got %0d required 64", got_n); else n_pass++;
      n_total++; if (anomalies !== 0) $display("FAIL stall_protocol: got %0d anomalies required 0", anomalies); else n_pass++;
      n_total++; if (count_bad(64) !== 0) $display("FAIL stall_words: got %0d bad words required 0", count_bad(64)); else n_pass++;
      $display("test_random_stall block %0d: %0d cycles", b, emit_cycles);
    end
  endtask

  task automatic test_load_gaps();
    int   early;
    logic fire;
    make_block(1'b0);
    load_n = 0; load_cycles = 0; early = 0;
    while (load_n < 16 && load_cycles < 1000) begin
      if (o_out_valid[0] !== 1'b0 || o_in_ready[0] !== 1'b1) early++;
      tb_in_valid[0] = (int'($urandom_range(99)) >= 50);
      tb_in_data[0]  = tb_in_valid[0] ? blk[load_n] : $urandom;
      tb_out_ready[0] = 1'($urandom_range(1));
      fire = tb_in_valid[0] & o_in_ready[0];
      @(posedge clk); #1;
      load_cycles++;
      if (fire) load_n++;
    end
    tb_in_valid[0] = 1'b0;
    tb_out_ready[0] = 1'b0;
    n_total++; if (load_n !== 16) $display("FAIL gaps_handshakes: got %0d required 16", load_n); else n_pass++;
    n_total++; if (early !== 0) $display("FAIL gaps_early_valid: got %0d cycles required 0", early); else n_pass++;
    n_total++; if (o_out_valid[0] !== 1'b1 || o_idx[0] !== 6'd0)
      $display("FAIL gaps_latency: got valid=%b idx=%0d required 1/0", o_out_valid[0], o_idx[0]); else n_pass++;
    n_total++; if (o_data[0] !== blk[0]) $display("FAIL gaps_w0: got %h required %h", o_data[0], blk[0]); else n_pass++;
    emit_collect(0, 64, 20);
    n_total++; if (count_bad(64) !== 0 || anomalies !== 0)
      $display("FAIL gaps_words: got %0d bad %0d anomalies required 0/0", count_bad(64), anomalies); else n_pass++;
    $display("test_load_gaps done: %0d load cycles", load_cycles);
  endtask

  task automatic test_clear();
    int k;
    make_block(1'b0);
    load_block(0, 5, 0);
    tb_clear[0] = 1'b1; tb_in_valid[0] = 1'b1; tb_in_data[0] = $urandom;
    @(posedge clk); #1;
    tb_clear[0] = 1'b0; tb_in_valid[0] = 1'b0;
    n_total++; if (o_out_valid[0] !== 1'b0 || o_in_ready[0] !== 1'b1)
      $display("FAIL clear_load: got valid=%b ready=%b required 0/1", o_out_valid[0], o_in_ready[0]); else n_pass++;
    load_block(0, 16, 20);
    n_total++; if (load_n !== 16) $display("FAIL clear_reload: got %0d handshakes required 16", load_n); else n_pass++;
    k = 0;
    while (o_idx[0] !== 6'd30 && k < 200) begin
      tb_out_ready[0] = 1'b1;
      @(posedge clk); #1;
      k++;
    end
    tb_out_ready[0] = 1'b0;
    @(posedge clk); #1;
    n_total++; if (o_idx[0] !== 6'd30 || o_data[0] !== ref_w[30])
      $display("FAIL clear_w30_stall: got idx=%0d data=%h required 30/%h", o_idx[0], o_data[0], ref_w[30]); else n_pass++;
    tb_clear[0] = 1'b1;
    @(posedge clk); #1;
    tb_clear[0] = 1'b0;
    n_total++; if (o_out_valid[0] !== 1'b0 || o_in_ready[0] !== 1'b1 || o_busy[0] !== 1'b0)
      $display("FAIL clear_state: got valid=%b ready=%b busy=%b required 0/1/0", o_out_valid[0], o_in_ready[0], o_busy[0]); else n_pass++;
    n_total++; if (o_idx[0] !== 6'd0 || o_last[0] !== 1'b0)
      $display("FAIL clear_idx: got idx=%0d last=%b required 0/0", o_idx[0], o_last[0]); else n_pass++;
    make_block(1'b0);
    load_block(0, 16, 0);
    emit_collect(0, 64, 25);
    n_total++; if (got_n !== 64 || count_bad(64) !== 0 || anomalies !== 0)
      $display("FAIL clear_fresh_block: got %0d words %0d bad %0d anomalies required 64/0/0", got_n, count_bad(64), anomalies); else n_pass++;
    $display("test_clear done");
  endtask

  task automatic test_reset_mid();
    int k;
    make_block(1'b0);
    load_block(0, 7, 0);
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (o_in_ready[0] !== 1'b1 || o_out_valid[0] !== 1'b0 || o_data[0] !== 32'h0)
      $display("FAIL rst_mid_load: got ready=%b valid=%b data=%h required 1/0/0", o_in_ready[0], o_out_valid[0], o_data[0]); else n_pass++;
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    make_block(1'b0);
    load_block(0, 16, 0);
    k = 0;
    while (o_idx[0] !== 6'd20 && k < 200) begin
      tb_out_ready[0] = 1'b1;
      @(posedge clk); #1;
      k++;
    end
    tb_out_ready[0] = 1'b0;
    n_total++; if (o_data[0] !== ref_w[20]) $display("FAIL rst_pre_emit_w20: got %h required %h", o_data[0], ref_w[20]); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (o_out_valid[0] !== 1'b0 || o_busy[0] !== 1'b0 || o_in_ready[0] !== 1'b1)
      $display("FAIL rst_mid_emit_ctrl: got valid=%b busy=%b ready=%b required 0/0/1", o_out_valid[0], o_busy[0], o_in_ready[0]); else n_pass++;
    n_total++; if (o_data[0] !== 32'h0 || o_idx[0] !== 6'd0 || o_last[0] !== 1'b0)
      $display("FAIL rst_mid_emit_data: got data=%h idx=%0d last=%b required 0/0/0", o_data[0], o_idx[0], o_last[0]); else n_pass++;
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    make_block(1'b0);
    load_block(0, 16, 10);
    emit_collect(0, 64, 10);
    n_total++; if (got_n !== 64 || count_bad(64) !== 0 || anomalies !== 0)
      $display("FAIL rst_next_block: got %0d words %0d bad %0d anomalies required 64/0/0", got_n, count_bad(64), anomalies); else n_pass++;
    $display("test_reset_mid done");
  endtask

  task automatic test_back_to_back_16();
    make_block(1'b0);
    load_block(1, 16, 0);
    emit_collect(1, 16, 0);
    n_total++; if (got_n !== 16 || emit_cycles !== 16)
      $display("FAIL r16_first_count: got %0d words in %0d cycles required 16/16", got_n, emit_cycles); else n_pass++;
    n_total++; if (anomalies !== 0) $display("FAIL r16_first_protocol: got %0d anomalies required 0", anomalies); else n_pass++;
    n_total++; if (count_bad(16) !== 0) $display("FAIL r16_first_words: got %0d bad required 0", count_bad(16)); else n_pass++;
    n_total++; if (o_in_ready[1] !== 1'b1 || o_out_valid[1] !== 1'b0)
      $display("FAIL r16_return_load: got ready=%b valid=%b required 1/0", o_in_ready[1], o_out_valid[1]); else n_pass++;
    make_block(1'b0);
    load_block(1, 16, 0);
    n_total++; if (load_cycles !== 16) $display("FAIL r16_second_load: got %0d cycles required 16", load_cycles); else n_pass++;
    emit_collect(1, 16, 30);
    n_total++; if (got_n !== 16 || anomalies !== 0 || count_bad(16) !== 0)
      $display("FAIL r16_second_block: got %0d words %0d anomalies %0d bad required 16/0/0", got_n, anomalies, count_bad(16)); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (o_out_valid[1] !== 1'b0) $display("FAIL r16_no_extra_word: got valid=%b required 0", o_out_valid[1]); else n_pass++;
    $display("test_back_to_back_16 done");
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      tb_clear[d] = 1'b0; tb_in_valid[d] = 1'b0; tb_in_data[d] = '0; tb_out_ready[d] = 1'b0;
    end
    rst_n = 1'b0;
    #3;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_abc();
    test_random_stall();
    test_load_gaps();
    test_clear();
    test_reset_mid();
    test_back_to_back_16();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
